// File: rtl/any1_issue_stage.sv
//-----------------------------------------------------------------------------
// any1_issue_stage
//
// Issue/dispatch stage that sits directly after the instruction scheduler.
// A valid scheduler selection (sel_i[6] == 0) is captured together with its
// operand bundle into a 2-entry skid queue. The queue head (slot S0) is
// presented to the execute unit over a valid/ready handshake. Every accepted
// selection produces exactly one registered set_out strobe the following
// cycle, so the ROB can mark that entry as issued.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   sel_i             scheduler selection, bit6=1 means "no selection"
//   sel_ir/pc/a/b/c_i operand bundle of the selected ROB entry
//   flush_i           kills all buffered issues (and same-cycle accept)
//   ex_rdy_i          execute unit accepts this cycle
//   ex_v/rid/ir/pc/a/b/c_o  registered issue bundle (head slot)
//   set_out_o, set_out_rid_o  one-cycle "mark ROB entry out" strobe
//   full_o            both slots occupied, current selection is dropped
//
// Optional feature (macro ANY1_ISSUE_STATS_EN):
//   stat_issued_o  saturating count of handshake (drain) cycles
//   stat_stall_o   saturating count of ex_v_o && !ex_rdy_i cycles
//   Both are cleared by reset only, never by flush.
//-----------------------------------------------------------------------------
module any1_issue_stage #(
  parameter int ROB_ENTRIES = 64,
  parameter int WID         = 64,
  parameter int IRW         = 40,
  localparam int RIDW       = $clog2(ROB_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RIDW:0]    sel_i,
  input  logic [IRW-1:0]   sel_ir_i,
  input  logic [31:0]      sel_pc_i,
  input  logic [WID-1:0]   sel_a_i,
  input  logic [WID-1:0]   sel_b_i,
  input  logic [WID-1:0]   sel_c_i,
  input  logic             flush_i,
  input  logic             ex_rdy_i,
  output logic             ex_v_o,
  output logic [RIDW-1:0]  ex_rid_o,
  output logic [IRW-1:0]   ex_ir_o,
  output logic [31:0]      ex_pc_o,
  output logic [WID-1:0]   ex_a_o,
  output logic [WID-1:0]   ex_b_o,
  output logic [WID-1:0]   ex_c_o,
  output logic             set_out_o,
  output logic [RIDW-1:0]  set_out_rid_o,
`ifdef ANY1_ISSUE_STATS_EN
  output logic             full_o,
  output logic [31:0]      stat_issued_o,
  output logic [31:0]      stat_stall_o
`else
  output logic             full_o
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [RIDW-1:0] rid;
    logic [IRW-1:0]  ir;
    logic [31:0]     pc;
    logic [WID-1:0]  a;
    logic [WID-1:0]  b;
    logic [WID-1:0]  c;
  } slot_t;

  state_e          state_q, state_d;
  slot_t           s0_q, s0_d;
  slot_t           s1_q, s1_d;
  logic            ex_v_q, ex_v_d;
  logic            set_out_q, set_out_d;
  logic [RIDW-1:0] set_out_rid_q, set_out_rid_d;
  slot_t           in_s;
  logic            acc_s;
  logic            drn_s;

  assign in_s  = '{rid: sel_i[RIDW-1:0], ir: sel_ir_i, pc: sel_pc_i,
                   a: sel_a_i, b: sel_b_i, c: sel_c_i};
  assign full_o = (state_q == ST_TWO);
  assign acc_s  = !sel_i[RIDW] && !full_o && !flush_i;
  assign drn_s  = ex_v_q && ex_rdy_i;

  // Next-state for the skid queue and the set_out strobe.
  always_comb begin
    state_d       = state_q;
    s0_d          = s0_q;
    s1_d          = s1_q;
    set_out_d     = 1'b0;
    set_out_rid_d = set_out_rid_q;
    if (flush_i) begin
      // Flush wins over any accept or drain in the same cycle.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc_s) begin
            s0_d    = in_s;
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (acc_s && drn_s) begin
            // Head leaves this cycle, so the newcomer becomes the head.
            s0_d    = in_s;
            state_d = ST_ONE;
          end else if (acc_s) begin
            s1_d    = in_s;
            state_d = ST_TWO;
          end else if (drn_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (drn_s) begin
            s0_d    = s1_q;
            state_d = ST_ONE;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
      set_out_d = acc_s;
      if (acc_s) begin
        set_out_rid_d = sel_i[RIDW-1:0];
      end else begin
        set_out_rid_d = set_out_rid_q;
      end
    end
    ex_v_d = (state_d != ST_EMPTY);
  end

  // State, slot data and registered strobe/valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_EMPTY;
      s0_q          <= '0;
      s1_q          <= '0;
      ex_v_q        <= 1'b0;
      set_out_q     <= 1'b0;
      set_out_rid_q <= '0;
    end else begin
      state_q       <= state_d;
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      ex_v_q        <= ex_v_d;
      set_out_q     <= set_out_d;
      set_out_rid_q <= set_out_rid_d;
    end
  end

  assign ex_v_o        = ex_v_q;
  assign ex_rid_o      = s0_q.rid;
  assign ex_ir_o       = s0_q.ir;
  assign ex_pc_o       = s0_q.pc;
  assign ex_a_o        = s0_q.a;
  assign ex_b_o        = s0_q.b;
  assign ex_c_o        = s0_q.c;
  assign set_out_o     = set_out_q;
  assign set_out_rid_o = set_out_rid_q;

`ifdef ANY1_ISSUE_STATS_EN
  logic [31:0] stat_issued_q;
  logic [31:0] stat_stall_q;

  // Saturating issue/stall counters; flush deliberately leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= 32'd0;
      stat_stall_q  <= 32'd0;
    end else begin
      if (drn_s && (stat_issued_q != 32'hFFFF_FFFF)) begin
        stat_issued_q <= stat_issued_q + 32'd1;
      end else begin
        stat_issued_q <= stat_issued_q;
      end
      if (ex_v_q && !ex_rdy_i && (stat_stall_q != 32'hFFFF_FFFF)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end else begin
        stat_stall_q <= stat_stall_q;
      end
    end
  end

  assign stat_issued_o = stat_issued_q;
  assign stat_stall_o  = stat_stall_q;
`endif

endmodule

// File: tb/tb_any1_issue_stage.sv
module tb_any1_issue_stage;

  typedef struct {
    logic [5:0]  rid;
    logic [39:0] ir;
    logic [31:0] pc;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  sel_i = 7'h40;
  logic [39:0] sel_ir_i = '0;
  logic [31:0] sel_pc_i = '0;
  logic [63:0] sel_a_i = '0, sel_b_i = '0, sel_c_i = '0;
  logic        flush_i = 1'b0;
  logic        ex_rdy_i = 1'b0;
  logic        ex_v_o;
  logic [5:0]  ex_rid_o;
  logic [39:0] ex_ir_o;
  logic [31:0] ex_pc_o;
  logic [63:0] ex_a_o, ex_b_o, ex_c_o;
  logic        set_out_o;
  logic [5:0]  set_out_rid_o;
  logic        full_o;
`ifdef ANY1_ISSUE_STATS_EN
  logic [31:0] stat_issued_o, stat_stall_o;
`endif

  any1_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .sel_i(sel_i), .sel_ir_i(sel_ir_i),
    .sel_pc_i(sel_pc_i), .sel_a_i(sel_a_i), .sel_b_i(sel_b_i),
    .sel_c_i(sel_c_i), .flush_i(flush_i), .ex_rdy_i(ex_rdy_i),
    .ex_v_o(ex_v_o), .ex_rid_o(ex_rid_o), .ex_ir_o(ex_ir_o),
    .ex_pc_o(ex_pc_o), .ex_a_o(ex_a_o), .ex_b_o(ex_b_o), .ex_c_o(ex_c_o),
    .set_out_o(set_out_o), .set_out_rid_o(set_out_rid_o),
`ifdef ANY1_ISSUE_STATS_EN
    .stat_issued_o(stat_issued_o), .stat_stall_o(stat_stall_o),
`endif
    .full_o(full_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the pending issues in order, at most two of them.
  item_t       exp_q[$];
  logic        exp_set_v = 1'b0;
  logic [5:0]  exp_set_rid = '0;
  int unsigned m_issued = 0, m_stall = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_set_v = 1'b0;
      m_issued  = 0;
      m_stall   = 0;
    end else begin
      automatic int  n   = exp_q.size();
      automatic bit  acc = !sel_i[6] && (n < 2) && !flush_i;
      automatic bit  drn = (n > 0) && ex_rdy_i;
      automatic item_t it;
      if (drn) m_issued++;
      if ((n > 0) && !ex_rdy_i) m_stall++;
      exp_set_v = acc;
      if (acc) exp_set_rid = sel_i[5:0];
      if (flush_i) begin
        exp_q.delete();
      end else begin
        if (drn) void'(exp_q.pop_front());
        if (acc) begin
          it.rid = sel_i[5:0]; it.ir = sel_ir_i; it.pc = sel_pc_i;
          it.a = sel_a_i; it.b = sel_b_i; it.c = sel_c_i;
          exp_q.push_back(it);
        end
      end
    end
  end

  // Monitor: compares every visible output against the model mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ex_v", ex_v_o, exp_q.size() != 0);
      check("full", full_o, exp_q.size() == 2);
      check("set_out", set_out_o, exp_set_v);
      if (exp_set_v && set_out_o) check("set_out_rid", set_out_rid_o, exp_set_rid);
      if (ex_v_o && exp_q.size() != 0) begin
        check("ex_rid", ex_rid_o, exp_q[0].rid);
        check("ex_ir",  ex_ir_o,  exp_q[0].ir);
        check("ex_pc",  ex_pc_o,  exp_q[0].pc);
        check("ex_a",   ex_a_o,   exp_q[0].a);
        check("ex_b",   ex_b_o,   exp_q[0].b);
        check("ex_c",   ex_c_o,   exp_q[0].c);
      end
`ifdef ANY1_ISSUE_STATS_EN
      check("stat_issued", stat_issued_o, m_issued);
      check("stat_stall",  stat_stall_o,  m_stall);
`endif
    end
  end

  // One clock with the given inputs; random operand payload each time.
  task automatic cyc(input logic [6:0] sel, input logic rdy, input logic fl);
    logic [63:0] r;
    sel_i = sel; ex_rdy_i = rdy; flush_i = fl;
    r = {$urandom(), $urandom()}; sel_ir_i = r[39:0];
    sel_pc_i = $urandom();
    sel_a_i = {$urandom(), $urandom()};
    sel_b_i = {$urandom(), $urandom()};
    sel_c_i = {$urandom(), $urandom()};
    @(posedge clk); #1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_ex_v", ex_v_o, 1'b0);
    check("reset_full", full_o, 1'b0);

    // Stream with ready high.
    cyc(7'd5, 1'b1, 1'b0);
    check("stream_rid5", ex_rid_o, 6'd5);
    cyc(7'd6, 1'b1, 1'b0);
    cyc(7'd7, 1'b1, 1'b0);
    check("stream_rid7", ex_rid_o, 6'd7);
    cyc(7'h40, 1'b1, 1'b0);

    // Backpressure: third selection dropped while full.
    cyc(7'd10, 1'b0, 1'b0);
    cyc(7'd11, 1'b0, 1'b0);
    check("bp_full", full_o, 1'b1);
    cyc(7'd12, 1'b0, 1'b0);
    check("bp_no_set12", set_out_o, 1'b0);
    cyc(7'h40, 1'b1, 1'b0);
    check("bp_rid11", ex_rid_o, 6'd11);
    cyc(7'h40, 1'b1, 1'b0);
    check("bp_empty", ex_v_o, 1'b0);

    // Hold under stall.
    cyc(7'd20, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(7'h40, 1'b0, 1'b0);
    check("hold_rid20", ex_rid_o, 6'd20);
    cyc(7'h40, 1'b1, 1'b0);

    // Flush with count 2 and a same-cycle selection.
    cyc(7'd28, 1'b0, 1'b0);
    cyc(7'd29, 1'b0, 1'b0);
    cyc(7'd30, 1'b0, 1'b1);
    check("flush_ex_v", ex_v_o, 1'b0);
    check("flush_no_set", set_out_o, 1'b0);

    // No-select then RID 63.
    for (int i = 0; i < 3; i++) cyc(7'h7F, 1'b1, 1'b0);
    cyc(7'h3F, 1'b1, 1'b0);
    check("rid63", ex_rid_o, 6'd63);
    cyc(7'h40, 1'b1, 1'b0);

    // Repeated RID is accepted twice.
    cyc(7'd9, 1'b0, 1'b0);
    cyc(7'd9, 1'b0, 1'b0);
    check("dup_full", full_o, 1'b1);

    // Asynchronous reset while two slots are occupied.
    #1 rst_n = 1'b0;
    #1;
    check("arst_ex_v", ex_v_o, 1'b0);
    check("arst_full", full_o, 1'b0);
    check("arst_set", set_out_o, 1'b0);
`ifdef ANY1_ISSUE_STATS_EN
    check("arst_issued", stat_issued_o, 32'd0);
    check("arst_stall", stat_stall_o, 32'd0);
`endif
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [6:0] s;
      s = 7'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) s[6] = 1'b1;
      cyc(s, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(7'h40, 1'b1, 1'b0);
    check("final_empty", ex_v_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
